fifo_memoria: RTL and testbench

Eight-entry synchronous FIFO that buffers data words and issues a one-cycle `push_ok` pulse for every accepted write. It sits directly upstream of `contador`: `push_ok` drives the counter's `push` input, so the 3-bit `cuenta` tallies accepted writes modulo 8. It also supplies the full, empty, almost-full, almost-empty and error status used by the memory testbench `probador`.

---
 rtl/fifo_memoria.sv | 125 ++++++++++++
 tb/tb_fifo_memoria.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_memoria.sv
// fifo_memoria: eight-entry synchronous FIFO with registered read data,
// a one-cycle push_ok pulse per accepted write (feeds contador.push),
// registered occupancy status flags and a sticky overflow/underflow error.
module fifo_memoria #(
  parameter int DATA_W       = 6,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              push_ok,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              err
);

  localparam logic [3:0] DEPTH     = 4'd8;
  localparam logic [3:0] AF_LEVEL  = 4'(ALMOST_FULL);
  localparam logic [3:0] AE_LEVEL  = 4'(ALMOST_EMPTY);

  logic [DATA_W-1:0] mem [8];
  logic [2:0]        wr_ptr;
  logic [2:0]        rd_ptr;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic              push_acc;
  logic              pop_acc;
  logic              req_drop;

  // Acceptance decisions and next occupancy, all based on the pre-edge count.
  // A push into a full FIFO is only taken when a pop frees a slot on the
  // same edge; a pop from an empty FIFO is never taken (no write-through).
  always_comb begin
    push_acc = 1'b0;
    pop_acc  = 1'b0;
    req_drop = 1'b0;
    cnt_next = cnt;
    pop_acc  = pop && (cnt != 4'd0);
    push_acc = push && ((cnt != DEPTH) || pop_acc);
    req_drop = (push && !push_acc) || (pop && !pop_acc);
    if (push_acc && !pop_acc) begin
      cnt_next = cnt + 4'd1;
    end else if (pop_acc && !push_acc) begin
      cnt_next = cnt - 4'd1;
    end
  end

  // Storage array; contents are never observable before being written,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at 3 bits.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      cnt    <= 4'd0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + 3'd1;
      end
      cnt <= cnt_next;
    end
  end

  // Registered read data: updated only on an accepted pop, held otherwise.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out <= '0;
    end else if (pop_acc) begin
      data_out <= mem[rd_ptr];
    end
  end

  // Single-cycle strobes for a freshly popped word and an accepted write.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_out <= 1'b0;
      push_ok   <= 1'b0;
    end else begin
      valid_out <= pop_acc;
      push_ok   <= push_acc;
    end
  end

  // Status flags registered from the post-edge occupancy so they always
  // describe the FIFO contents visible in the current cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      full         <= (cnt_next == DEPTH);
      empty        <= (cnt_next == 4'd0);
      almost_full  <= (cnt_next >= AF_LEVEL);
      almost_empty <= (cnt_next <= AE_LEVEL);
    end
  end

  // Sticky error: any dropped push or pop latches it until reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err <= 1'b0;
    end else if (req_drop) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_memoria.sv
// tb_fifo_memoria: table-driven and hand-sequenced checks of fifo_memoria,
// with a data scoreboard queue and a small push_ok counter standing in for
// the downstream contador.
module tb_fifo_memoria;

  logic       clk;
  logic       reset_L;
  logic       push;
  logic       pop;
  logic [5:0] data_in;
  logic [5:0] data_out;
  logic       valid_out;
  logic       push_ok;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       err;

  int         checks;
  int         errors;
  int         modelCnt;
  logic [5:0] sb [$];
  logic [5:0] lastData;
  logic [2:0] cuenta;

  typedef struct {
    logic       push;
    logic       pop;
    logic [5:0] data;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [16];

  fifo_memoria #(.DATA_W(6), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .push_ok      (push_ok),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .err          (err)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for contador: counts push_ok pulses modulo 8.
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cuenta <= 3'd0;
    end else if (push_ok) begin
      cuenta <= cuenta + 3'd1;
    end
  end

  // Drive one cycle of requests, update the reference occupancy and
  // scoreboard, then step past the edge so outputs can be sampled.
  task automatic applyStimulus(input logic p, input logic q, input logic [5:0] d);
    logic pushAcc;
    logic popAcc;
    push    = p;
    pop     = q;
    data_in = d;
    popAcc  = q && (modelCnt > 0);
    pushAcc = p && ((modelCnt < 8) || popAcc);
    if (pushAcc) sb.push_back(d);
    if (pushAcc && !popAcc) modelCnt = modelCnt + 1;
    if (popAcc && !pushAcc) modelCnt = modelCnt - 1;
    @(posedge clk);
    #1;
  endtask

  // Compare every status output against the expectation vector
  // {push_ok, valid_out, full, empty, almost_full, almost_empty, err},
  // then check data_out against the scoreboard or against its held value.
  task automatic checkOutput(input string name, input logic [6:0] exp);
    logic [6:0] act;
    logic [5:0] want;
    string      fld [7];
    fld = '{"push_ok", "valid_out", "full", "empty", "almost_full", "almost_empty", "err"};
    act = {push_ok, valid_out, full, empty, almost_full, almost_empty, err};
    for (int b = 0; b < 7; b++) begin
      checks++;
      if (act[6-b] !== exp[6-b]) begin
        errors++;
        $display("[TB] FAIL %s.%s actual=%b required=%b", name, fld[b], act[6-b], exp[6-b]);
      end
    end
    checks++;
    if (exp[5]) begin
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL %s.data_out actual=%h required=<scoreboard empty>", name, data_out);
      end else begin
        want = sb.pop_front();
        lastData = want;
        if (data_out !== want) begin
          errors++;
          $display("[TB] FAIL %s.data_out actual=%h required=%h", name, data_out, want);
        end
      end
    end else if (data_out !== lastData) begin
      errors++;
      $display("[TB] FAIL %s.data_hold actual=%h required=%h", name, data_out, lastData);
    end
  endtask

  // Assert reset away from any clock edge, check outputs immediately,
  // then release on the falling edge.
  task automatic doReset(input string name);
    @(negedge clk);
    #2;
    reset_L  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    lastData = 6'h00;
    #1;
    checkOutput(name, 7'b0001010);
    modelCnt = 0;
    sb.delete();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    modelCnt = 0;
    lastData = 6'h00;
    reset_L  = 1'b0;
    push     = 1'b1;
    pop      = 1'b0;
    data_in  = 6'h15;

    // Fill then drain, expectations written out per step.
    for (int i = 0; i < 8; i++) begin
      vecs[i].push = 1'b1;
      vecs[i].pop  = 1'b0;
      vecs[i].data = 6'(i + 1);
    end
    for (int i = 8; i < 16; i++) begin
      vecs[i].push = 1'b0;
      vecs[i].pop  = 1'b1;
      vecs[i].data = 6'h00;
    end
    vecs[0].exp  = 7'b1000010;
    vecs[1].exp  = 7'b1000010;
    vecs[2].exp  = 7'b1000000;
    vecs[3].exp  = 7'b1000000;
    vecs[4].exp  = 7'b1000000;
    vecs[5].exp  = 7'b1000100;
    vecs[6].exp  = 7'b1000100;
    vecs[7].exp  = 7'b1010100;
    vecs[8].exp  = 7'b0100100;
    vecs[9].exp  = 7'b0100100;
    vecs[10].exp = 7'b0100000;
    vecs[11].exp = 7'b0100000;
    vecs[12].exp = 7'b0100000;
    vecs[13].exp = 7'b0100010;
    vecs[14].exp = 7'b0100010;
    vecs[15].exp = 7'b0101010;

    // Reset held across edges with push asserted: nothing may be accepted.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", 7'b0001010);
    @(negedge clk);
    reset_L = 1'b1;
    push    = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      if (i == 4) begin
        checks++;
        if (cuenta !== 3'd4) begin
          errors++;
          $display("[TB] FAIL cuenta_mid actual=%0d required=4", cuenta);
        end
      end
    end
    #1;
    checks++;
    if (cuenta !== 3'd0) begin
      errors++;
      $display("[TB] FAIL cuenta_wrap actual=%0d required=0", cuenta);
    end

    // Underflow, then simultaneous push/pop on an empty FIFO.
    applyStimulus(1'b0, 1'b1, 6'h00);
    checkOutput("pop_empty", 7'b0001011);
    applyStimulus(1'b1, 1'b1, 6'h2A);
    checkOutput("pushpop_empty", 7'b1000011);
    applyStimulus(1'b0, 1'b1, 6'h00);
    checkOutput("drain_2a", 7'b0101011);

    // Fill, then push+pop at full across pointer wrap, then overflow.
    doReset("reset_c");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 6'(8'h10 + i));
      checkOutput($sformatf("fill%0d", i),
                  {1'b1, 1'b0, (i == 7), 1'b0, (i >= 5), (i <= 1), 1'b0});
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 6'(8'h20 + i));
      checkOutput($sformatf("pp_full%0d", i), 7'b1110100);
    end
    applyStimulus(1'b1, 1'b0, 6'h3F);
    checkOutput("overflow", 7'b0010101);
    applyStimulus(1'b0, 1'b0, 6'h00);
    checkOutput("err_sticky", 7'b0010101);
    applyStimulus(1'b0, 1'b1, 6'h00);
    checkOutput("pop_oldest", 7'b0100101);

    // Five words stored, then asynchronous reset mid-cycle.
    doReset("reset_d");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 6'(8'h31 + i));
      checkOutput($sformatf("load%0d", i),
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (i <= 1), 1'b0});
    end
    doReset("async_reset");
    applyStimulus(1'b0, 1'b1, 6'h00);
    checkOutput("pop_after_reset", 7'b0001011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
